// File: rtl/serial_adder_sub.sv
// serial_adder_sub: bit-serial add/subtract, BPC bits per clock, carry held in a flop.
// Ports: clk, rst_n, start/sub/a/b/cin in; ready, done, sum, cout, overflow out.
// Optional macro SERIAL_ADDER_SUB_OVF_EN builds signed-overflow tracking
// (otherwise overflow is tied to 0).
module serial_adder_sub #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_q, sum_nx;
    logic             carry, cout_q;
    logic [CW-1:0]    count;
    logic [BPC-1:0]   slice_s;
    logic             slice_co;
    logic             last;

    // Ripple slice of BPC full adders over the operand LSBs.
`ifdef SERIAL_ADDER_SUB_OVF_EN
    logic msb_ci;
    logic ovf_q;
`endif

    always_comb begin
        logic c;
        c       = carry;
        slice_s = '0;
`ifdef SERIAL_ADDER_SUB_OVF_EN
        msb_ci  = 1'b0;
`endif
        for (int i = 0; i < BPC; i++) begin
`ifdef SERIAL_ADDER_SUB_OVF_EN
            if (i == BPC - 1) msb_ci = c;
`endif
            slice_s[i] = a_sh[i] ^ b_sh[i] ^ c;
            c = (a_sh[i] & b_sh[i]) | (c & (a_sh[i] ^ b_sh[i]));
        end
        slice_co = c;
    end

    // New chunk enters at the MSB end; after N chunks the LSB chunk sits at bit 0.
    assign sum_nx = WIDTH'({slice_s, sum_sh} >> BPC);
    assign last   = (count == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            count  <= '0;
`ifdef SERIAL_ADDER_SUB_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        count <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> BPC;
                    b_sh   <= b_sh >> BPC;
                    sum_sh <= sum_nx;
                    carry  <= slice_co;
                    count  <= count + CW'(1);
                    if (last) begin
                        sum_q  <= sum_nx;
                        cout_q <= slice_co;
`ifdef SERIAL_ADDER_SUB_OVF_EN
                        ovf_q  <= msb_ci ^ slice_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;
`ifdef SERIAL_ADDER_SUB_OVF_EN
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_sub.sv
// tb_serial_adder_sub: directed + random checks of serial_adder_sub
// for BPC=1 and BPC=4 instances (WIDTH=8), scoreboard-based.
module tb_serial_adder_sub;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       start8 = 0, start4 = 0;
    logic       sub = 0, cin = 0;
    logic [7:0] a = 0, b = 0;
    logic       use4 = 0;

    logic       ready8, done8, cout8, ovf8;
    logic       ready4, done4, cout4, ovf4;
    logic [7:0] sum8, sum4;
    logic       r_ready, r_done, r_cout, r_ovf;
    logic [7:0] r_sum;

`ifdef SERIAL_ADDER_SUB_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } res_t;

    res_t sb[$];
    int   vectors = 0;
    int   miscmp  = 0;

    serial_adder_sub #(.WIDTH(8), .BPC(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub),
        .a(a), .b(b), .cin(cin), .ready(ready8), .done(done8),
        .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_adder_sub #(.WIDTH(8), .BPC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub),
        .a(a), .b(b), .cin(cin), .ready(ready4), .done(done4),
        .sum(sum4), .cout(cout4), .overflow(ovf4)
    );

    always #5 clk = ~clk;

    always_comb begin
        r_ready = use4 ? ready4 : ready8;
        r_done  = use4 ? done4  : done8;
        r_sum   = use4 ? sum4   : sum8;
        r_cout  = use4 ? cout4  : cout8;
        r_ovf   = use4 ? ovf4   : ovf8;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb,
                                   input logic mc, input logic ms);
        logic [8:0] t;
        logic [7:0] bb;
        res_t       r;
        bb  = ms ? ~mb : mb;
        t   = {1'b0, ma} + {1'b0, bb} + {8'b0, (ms ? 1'b1 : mc)};
        r.s = t[7:0];
        r.c = t[8];
        r.o = OVF & (ma[7] == bb[7]) & (t[7] != ma[7]);
        return r;
    endfunction

    task automatic run_op(input bit w4, input logic [7:0] ia,
                          input logic [7:0] ib, input logic ic,
                          input logic is, input res_t exp,
                          input bit repulse);
        int   n;
        int   k;
        bit   seen;
        res_t r;
        n = w4 ? 2 : 8;
        @(negedge clk);
        use4 = w4;
        a = ia; b = ib; cin = ic; sub = is;
        if (w4) start4 = 1; else start8 = 1;
        sb.push_back(exp);
        @(posedge clk); #1;
        start4 = 0; start8 = 0;
        check("ready_drop", r_ready, 0);
        a = ~ia; b = ~ib; cin = ~ic; sub = ~is;
        seen = 0;
        k = 0;
        while (!seen && k < n + 4) begin
            if (repulse && k == 2) begin
                start8 = 1; a = 0; b = 0;
            end
            if (repulse && k == 5) start8 = 0;
            @(posedge clk); #1;
            k++;
            if (r_done) seen = 1;
        end
        start8 = 0;
        check("done_seen", seen, 1);
        check("latency", k, n);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            r = sb.pop_front();
            check("sum", r_sum, r.s);
            check("cout", r_cout, r.c);
            check("ovf", r_ovf, r.o);
        end
        @(posedge clk); #1;
        check("done_pulse", r_done, 0);
        check("ready_back", r_ready, 1);
        check("sum_hold", r_sum, exp.s);
    endtask

    initial begin
        res_t e;
        int   ndone;
        logic [7:0] ra, rb;
        logic rc, rs;

        #12;
        check("rst_ready8", ready8, 1);
        check("rst_done8", done8, 0);
        check("rst_sum8", sum8, 8'h00);
        check("rst_cout8", cout8, 0);
        check("rst_ovf8", ovf8, 0);
        check("rst_ready4", ready4, 1);
        @(negedge clk);
        rst_n = 1;

        e = '{s: 8'h96, c: 1'b0, o: OVF};
        run_op(0, 8'h5A, 8'h3C, 0, 0, e, 0);
        e = '{s: 8'h01, c: 1'b1, o: 1'b0};
        run_op(0, 8'hFF, 8'h01, 1, 0, e, 0);
        e = '{s: 8'hF0, c: 1'b0, o: 1'b0};
        run_op(0, 8'h10, 8'h20, 1, 1, e, 0);
        e = '{s: 8'h96, c: 1'b0, o: OVF};
        run_op(0, 8'h5A, 8'h3C, 0, 0, e, 1);

        @(negedge clk);
        use4 = 0;
        a = 8'h5A; b = 8'h3C; cin = 0; sub = 0;
        start8 = 1;
        @(posedge clk); #1;
        start8 = 0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("mid_rst_ready", ready8, 1);
        check("mid_rst_done", done8, 0);
        check("mid_rst_sum", sum8, 8'h00);
        check("mid_rst_cout", cout8, 0);
        check("mid_rst_ovf", ovf8, 0);
        @(negedge clk);
        rst_n = 1;
        ndone = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        check("mid_rst_nodone", ndone, 0);
        e = '{s: 8'h03, c: 1'b0, o: 1'b0};
        run_op(0, 8'h01, 8'h02, 0, 0, e, 0);

        e = '{s: 8'h80, c: 1'b0, o: OVF};
        run_op(1, 8'h7F, 8'h01, 0, 0, e, 0);

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            run_op(i[0], ra, rb, rc, rs, model(ra, rb, rc, rs), 0);
        end

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
        $finish;
    end

endmodule
